ila_dma_framer: RTL

ILA_DMA_FRAMER -- requirements
Module: ila_dma_framer

---
 rtl/ila_dma_framer.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/ila_dma_framer.sv
// Frames ILA buffer readout words for DMA: a header word, then n payload words.
// Defining IOB_ILA_FRAMER_CSUM_EN appends an XOR checksum trailer word.
module ila_dma_framer #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned LEN_W  = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              cke_i,
  input  logic              start_i,
  input  logic              abort_i,
  input  logic [LEN_W-1:0]  n_words_i,
  input  logic [DATA_W-1:0] s_tdata_i,
  input  logic              s_tvalid_i,
  output logic              s_tready_o,
  output logic [DATA_W-1:0] m_tdata_o,
  output logic              m_tvalid_o,
  output logic              m_tlast_o,
  input  logic              m_tready_i,
  output logic              busy_o,
  output logic              done_o
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_HEADER,
`ifdef IOB_ILA_FRAMER_CSUM_EN
    S_PAYLOAD,
    S_TRAILER
`else
    S_PAYLOAD
`endif
  } state_t;

  state_t              state_q, state_d;
  logic [LEN_W-1:0]    n_words_q, n_words_d;
  logic [LEN_W-1:0]    cnt_q, cnt_d;
  logic [DATA_W-1:0]   tdata_q, tdata_d;
  logic                tvalid_q, tvalid_d;
  logic                tlast_q, tlast_d;
  logic                done_q, done_d;
  logic [DATA_W-1:0]   hdr;
  logic                s_ready, in_acc, out_acc;
`ifdef IOB_ILA_FRAMER_CSUM_EN
  logic [DATA_W-1:0]   csum_q, csum_d;
`endif

  // Single output register stage; a new input word may enter as the held one drains.
  assign out_acc = tvalid_q & m_tready_i;
  assign s_ready = cke_i && (state_q == S_PAYLOAD) && (cnt_q != n_words_q) &&
                   (!tvalid_q || m_tready_i);
  assign in_acc  = s_ready & s_tvalid_i;

  always_comb begin
    state_d   = state_q;
    n_words_d = n_words_q;
    cnt_d     = cnt_q;
    tdata_d   = tdata_q;
    tvalid_d  = tvalid_q;
    tlast_d   = tlast_q;
    done_d    = 1'b0;
`ifdef IOB_ILA_FRAMER_CSUM_EN
    csum_d    = csum_q;
`endif
    hdr                   = '0;
    hdr[DATA_W-1 -: 8]    = 8'hA5;
    hdr[LEN_W-1:0]        = n_words_i;

    if (abort_i) begin
      state_d  = S_IDLE;
      tvalid_d = 1'b0;
      tlast_d  = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            n_words_d = n_words_i;
            cnt_d     = '0;
            tdata_d   = hdr;
            tvalid_d  = 1'b1;
`ifdef IOB_ILA_FRAMER_CSUM_EN
            tlast_d   = 1'b0;
            csum_d    = '0;
`else
            tlast_d   = (n_words_i == '0);
`endif
            state_d   = S_HEADER;
          end
        end
        S_HEADER: begin
          if (out_acc) begin
            if (n_words_q != '0) begin
              state_d  = S_PAYLOAD;
              tvalid_d = 1'b0;
            end else begin
`ifdef IOB_ILA_FRAMER_CSUM_EN
              state_d  = S_TRAILER;
              tdata_d  = '0;
              tlast_d  = 1'b1;
`else
              state_d  = S_IDLE;
              tvalid_d = 1'b0;
              tlast_d  = 1'b0;
              done_d   = 1'b1;
`endif
            end
          end
        end
        S_PAYLOAD: begin
          if (in_acc) begin
            tdata_d  = s_tdata_i;
            tvalid_d = 1'b1;
            cnt_d    = cnt_q + 1'b1;
`ifdef IOB_ILA_FRAMER_CSUM_EN
            csum_d   = csum_q ^ s_tdata_i;
            tlast_d  = 1'b0;
`else
            tlast_d  = (cnt_q == n_words_q - 1'b1);
`endif
          end else if (out_acc) begin
            tvalid_d = 1'b0;
`ifndef IOB_ILA_FRAMER_CSUM_EN
            if (tlast_q) begin
              state_d = S_IDLE;
              tlast_d = 1'b0;
              done_d  = 1'b1;
            end
`endif
          end
`ifdef IOB_ILA_FRAMER_CSUM_EN
          // Trailer is loaded as soon as the output slot frees after the last payload word.
          if (!in_acc && (cnt_q == n_words_q) && (!tvalid_q || out_acc)) begin
            state_d  = S_TRAILER;
            tdata_d  = csum_q;
            tvalid_d = 1'b1;
            tlast_d  = 1'b1;
          end
`endif
        end
`ifdef IOB_ILA_FRAMER_CSUM_EN
        S_TRAILER: begin
          if (out_acc) begin
            state_d  = S_IDLE;
            tvalid_d = 1'b0;
            tlast_d  = 1'b0;
            done_d   = 1'b1;
          end
        end
`endif
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= S_IDLE;
      n_words_q <= '0;
      cnt_q     <= '0;
      tdata_q   <= '0;
      tvalid_q  <= 1'b0;
      tlast_q   <= 1'b0;
      done_q    <= 1'b0;
`ifdef IOB_ILA_FRAMER_CSUM_EN
      csum_q    <= '0;
`endif
    end else if (cke_i) begin
      state_q   <= state_d;
      n_words_q <= n_words_d;
      cnt_q     <= cnt_d;
      tdata_q   <= tdata_d;
      tvalid_q  <= tvalid_d;
      tlast_q   <= tlast_d;
      done_q    <= done_d;
`ifdef IOB_ILA_FRAMER_CSUM_EN
      csum_q    <= csum_d;
`endif
    end
  end

  assign s_tready_o = s_ready;
  assign m_tdata_o  = tdata_q;
  assign m_tvalid_o = tvalid_q;
  assign m_tlast_o  = tlast_q;
  assign busy_o     = (state_q != S_IDLE);
  assign done_o     = done_q;

endmodule
